// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared widths, FIFO depth and a clog2 helper for the Booth multiplier share arbiter
package booth_arb_pkg;
    localparam int OP_W = 8;
    localparam int P_W = 16;
    localparam int FIFO_DEPTH = 2;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/booth_8x8_radix_4_exact.sv
// booth_8x8_radix_4_exact: unsigned 8x8 radix-4 Booth multiplier, operands registered, product combinational
module booth_8x8_radix_4_exact #(
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   x,
    input  logic [7:0]   y,
    output logic [M-1:0] p
);
    logic [7:0]   r_x;
    logic [7:0]   r_y;
    logic [10:0]  w_yb;
    logic [M-1:0] w_xe;
    function automatic logic [M-1:0] pp(input logic [2:0] d, input logic [M-1:0] a);
        return (d == 3'b001 || d == 3'b010) ? a :
               (d == 3'b011) ? (a << 1) :
               (d == 3'b100) ? -(a << 1) :
               (d == 3'b101 || d == 3'b110) ? -a : '0;
    endfunction
    assign w_yb = {2'b00, r_y, 1'b0};
    assign w_xe = M'(r_x);
    // capture the operand pair; the product follows combinationally in the next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= x;
            r_y <= y;
        end
    end
    // five recoded digits over the zero-extended multiplier, each weighted by 4^k
    always_comb begin
        p = '0;
        for (int k = 0; k < 5; k++) p = p + (pp(w_yb[2*k+2 -: 3], w_xe) << (2 * k));
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant over valid requesters, pointer advances past each accepted winner
module rr_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW = clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_valid,
    input  logic            i_accept,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_gid
);
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_idx;
    logic           w_found;
    // first valid requester at or after the pointer, wrapping around
    always_comb begin
        o_grant = '0;
        o_gid = '0;
        w_idx = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && i_valid[w_idx]) begin
                w_found = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_gid = w_idx;
            end
        end
    end
    // pointer moves just past the winner only when its request was taken
    always_ff @(posedge clk) begin
        if (rst) r_ptr <= '0;
        else if (i_accept) r_ptr <= IDW'((int'(o_gid) + 1) % NREQ);
    end
endmodule

// File: rtl/booth_mult_share_arbiter.sv
// booth_mult_share_arbiter: round-robin sharing of one Booth multiplier with a tagged 2-entry result FIFO
module booth_mult_share_arbiter
    import booth_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW = clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_x,
    input  logic [NREQ*OP_W-1:0] req_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [P_W-1:0]       rsp_p,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);
    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam int PW = clog2(FIFO_DEPTH);
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gid;
    logic            w_can_issue;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [OP_W-1:0] w_mx;
    logic [OP_W-1:0] w_my;
    logic [P_W-1:0]  w_p;
    logic            r_inflight;
    logic [IDW-1:0]  r_id;
    logic [P_W-1:0]  r_fp [FIFO_DEPTH];
    logic [IDW-1:0]  r_fid [FIFO_DEPTH];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_cnt;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk(clk),
        .rst(rst),
        .i_valid(req_valid),
        .i_accept(w_accept),
        .o_grant(w_grant),
        .o_gid(w_gid)
    );

    booth_8x8_radix_4_exact #(.M(P_W)) u_mult (
        .clk(clk),
        .rst(rst),
        .x(w_mx),
        .y(w_my),
        .p(w_p)
    );

    assign rsp_valid = r_cnt != '0;
    assign w_pop = rsp_valid & rsp_ready;
    assign w_push = r_inflight;
    // a slot is free if FIFO plus in-flight op leave room, or the head leaves this very cycle
    assign w_can_issue = (int'(r_cnt) + int'(r_inflight) < FIFO_DEPTH) ||
                         (int'(r_cnt) + int'(r_inflight) == FIFO_DEPTH && w_pop);
    assign req_ready = (rst || !w_can_issue) ? '0 : w_grant;
    assign w_accept = |(req_valid & req_ready);
    assign w_mx = w_accept ? req_x[int'(w_gid)*OP_W +: OP_W] : '0;
    assign w_my = w_accept ? req_y[int'(w_gid)*OP_W +: OP_W] : '0;
    assign rsp_p = rsp_valid ? r_fp[r_rd] : '0;
    assign rsp_id = rsp_valid ? r_fid[r_rd] : '0;
    assign busy = r_inflight | rsp_valid;

    // inflight stage: tags the product that the multiplier presents in the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_id <= '0;
        end else begin
            r_inflight <= w_accept;
            r_id <= w_gid;
        end
    end

    // in-order result FIFO; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd <= '0;
            r_wr <= '0;
            r_cnt <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_fp[k] <= '0;
                r_fid[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fp[r_wr] <= w_p;
                r_fid[r_wr] <= r_id;
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && int'(r_cnt) == FIFO_DEPTH));
endmodule

// File: tb/tb_booth_mult_share_arbiter.sv
// tb_booth_mult_share_arbiter: scoreboard bench for the shared Booth multiplier arbiter
module tb_booth_mult_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW = 2;
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    p;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_x = '0;
    logic [NREQ*8-1:0] req_y = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [15:0]       rsp_p;
    logic [IDW-1:0]    rsp_id;
    logic              busy;
    logic [15:0]       exp_p [NREQ];
    rsp_t              exp_q [$];
    rsp_t              mon_e;
    int                checks = 0;
    int                errors = 0;

    booth_mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_x(req_x),
        .req_y(req_y),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_p(rsp_p),
        .rsp_id(rsp_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
        req_x[i*8 +: 8] = x;
        req_y[i*8 +: 8] = y;
        exp_p[i] = e;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: id %0d got no ready want ready", i);
        end
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("drain_busy", busy, 0);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // accept observer: pushes the expected response for every handshake it sees
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
            chk("ready_without_valid", 32'(req_ready & ~req_valid), 0);
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i]) exp_q.push_back(rsp_t'{id: IDW'(i), p: exp_p[i]});
        end
    end

    // response monitor: pops and compares every result the consumer takes
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d p %0h want none", rsp_id, rsp_p);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", rsp_id, mon_e.id);
                chk("rsp_p", rsp_p, mon_e.p);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] acc;
        logic [7:0] rx, ry;
        for (int i = 0; i < NREQ; i++) exp_p[i] = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_p", rsp_p, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_busy", busy, 0);
        // single request, latency and busy timing
        tick();
        rsp_ready = 1'b1;
        set_req(1, 8'd200, 8'd150, 16'h7530);
        @(negedge clk);
        chk("single_ready", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("single_t1_rsp_valid", rsp_valid, 0);
        chk("single_t1_busy", busy, 1);
        @(negedge clk);
        chk("single_t2_rsp_valid", rsp_valid, 1);
        chk("single_t2_rsp_p", rsp_p, 16'h7530);
        chk("single_t2_rsp_id", rsp_id, 1);
        @(negedge clk);
        chk("single_busy_after_pop", busy, 0);
        chk("single_rsp_valid_after_pop", rsp_valid, 0);
        tick();
        set_req(3, 8'd255, 8'd1, 16'h00FF);
        wait_accept(3);
        drain();
        // all four requesters streaming; pointer is back at 0
        set_req(0, 8'd255, 8'd255, 16'hFE01);
        set_req(1, 8'd0, 8'd173, 16'h0000);
        set_req(2, 8'd1, 8'd128, 16'h0080);
        set_req(3, 8'd128, 8'd2, 16'h0100);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("stream_grant", req_ready, 32'(1 << (k % 4)));
            if (k >= 2) chk("stream_rsp_valid", rsp_valid, 1);
        end
        tick();
        req_valid = '0;
        drain();
        // backpressure: two accepts fill the pipeline, head held stable
        rsp_ready = 1'b0;
        set_req(0, 8'd12, 8'd13, 16'h009C);
        set_req(2, 8'd255, 8'd1, 16'h00FF);
        @(negedge clk);
        chk("bp_grant0", req_ready, 4'b0001);
        @(negedge clk);
        chk("bp_grant2", req_ready, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_ready_low", req_ready, 0);
            chk("bp_head_valid", rsp_valid, 1);
            chk("bp_head_id", rsp_id, 0);
            chk("bp_head_p", rsp_p, 16'h009C);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_with_pop", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        drain();
        // reset with an op in flight and a buffered result
        rsp_ready = 1'b0;
        set_req(1, 8'd3, 8'd4, 16'h000C);
        set_req(2, 8'd5, 8'd6, 16'h001E);
        @(negedge clk);
        chk("rst_fill_grant1", req_ready, 4'b0010);
        @(negedge clk);
        chk("rst_fill_grant2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_req_ready", req_ready, 0);
        tick();
        rsp_ready = 1'b1;
        set_req(3, 8'd7, 8'd9, 16'h003F);
        set_req(0, 8'd16, 8'd16, 16'h0100);
        @(negedge clk);
        chk("rst_ptr_grant0", req_ready, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_then_grant3", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        drain();
        // random stress against the x*y model
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        rx = 8'($urandom);
                        ry = 8'($urandom);
                        set_req(i, rx, ry, 16'(rx) * 16'(ry));
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        tick();
        req_valid = '0;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
